// File: rtl/scan_pkg.sv
// Shared types, decoder enable patterns and the round-robin slot search
// used by the decoder scan sequencer.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  typedef struct packed {
    logic g1;
    logic g2a;
    logic g2b;
  } dec_en_t;

  localparam dec_en_t DEC_ON  = 3'b100;
  localparam dec_en_t DEC_OFF = 3'b011;

  typedef struct packed {
    logic       wrap;
    logic [2:0] idx;
  } slot_t;

  // First set mask bit strictly after sel, wrapping 7->0; a lone bit finds itself.
  function automatic slot_t next_slot(input logic [7:0] mask, input logic [2:0] sel);
    slot_t      r;
    logic       found;
    logic [2:0] i;
    r.idx  = sel;
    r.wrap = 1'b0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      i = sel + 3'(k);
      if (!found && mask[i]) begin
        found = 1'b1;
        r.idx = i;
      end
    end
    r.wrap = (r.idx <= sel);
    return r;
  endfunction

  function automatic logic [7:0] strobe_n(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-side signals of the scan sequencer. The master is the
// sequencer; the slave is the surrounding timing logic plus the decoder.
interface decoder_scan_ctrl_if;
  logic       EN;
  logic [7:0] MASK;
  logic       C;
  logic       B;
  logic       A;
  logic       G1;
  logic       G2A;
  logic       G2B;
  logic [7:0] Y_N;
  logic       BUSY;
  logic       FRAME;

  modport master (
    input  EN, MASK,
    output C, B, A, G1, G2A, G2B, Y_N, BUSY, FRAME
  );

  modport slave (
    output EN, MASK,
    input  C, B, A, G1, G2A, G2B, Y_N, BUSY, FRAME
  );
endinterface

// File: rtl/scan_sel_search.sv
// Combinational 8-bit round-robin search: next enabled slot after start_i.
module scan_sel_search
  import scan_pkg::*;
(
  input  logic [7:0] mask_i,
  input  logic [2:0] start_i,
  output logic [2:0] idx_o,
  output logic       valid_o,
  output logic       wrap_o
);
  slot_t res;

  assign res     = next_slot(mask_i, start_i);
  assign idx_o   = res.idx;
  assign wrap_o  = res.wrap;
  assign valid_o = |mask_i;
endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for an active-low 3-to-8 decoder: round-robin over enabled
// slots with a blanking gap before each slot and a FRAME pulse on wrap.
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic                CLK,
  input  logic                CLR_N,
  decoder_scan_ctrl_if.master bus,
  output state_e              dbg_state_o
);
  localparam logic [15:0] CNT_DRIVE = 16'(DIV - 1);
  localparam logic [15:0] CNT_BLANK = 16'(BLANK - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  sel_q;
  dec_en_t     dec_q;
  logic [7:0]  y_n_q;
  logic        busy_q;
  logic        frame_q;

  logic [2:0]  srch_idx;
  logic        srch_valid;
  logic        srch_wrap;
  logic        boundary;

  // Searching from 7 out of IDLE lands on the lowest set bit.
  scan_sel_search u_search (
    .mask_i  (bus.MASK),
    .start_i ((state_q == ST_IDLE) ? 3'd7 : sel_q),
    .idx_o   (srch_idx),
    .valid_o (srch_valid),
    .wrap_o  (srch_wrap)
  );

  assign boundary = (state_q == ST_IDLE) || ((state_q == ST_DRIVE) && (cnt_q == '0));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      dec_q   <= DEC_OFF;
      y_n_q   <= 8'hFF;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (!bus.EN) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        dec_q   <= DEC_OFF;
        y_n_q   <= 8'hFF;
        busy_q  <= 1'b0;
      end else if (boundary) begin
        if (srch_valid) begin
          sel_q   <= srch_idx;
          frame_q <= srch_wrap && (state_q == ST_DRIVE);
          busy_q  <= 1'b1;
          if (BLANK == 0) begin
            state_q <= ST_DRIVE;
            cnt_q   <= CNT_DRIVE;
            dec_q   <= DEC_ON;
            y_n_q   <= strobe_n(srch_idx);
          end else begin
            state_q <= ST_BLANK;
            cnt_q   <= CNT_BLANK;
            dec_q   <= DEC_OFF;
            y_n_q   <= 8'hFF;
          end
        end else begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          dec_q   <= DEC_OFF;
          y_n_q   <= 8'hFF;
          busy_q  <= 1'b0;
        end
      end else if ((state_q == ST_BLANK) && (cnt_q == '0)) begin
        state_q <= ST_DRIVE;
        cnt_q   <= CNT_DRIVE;
        dec_q   <= DEC_ON;
        y_n_q   <= strobe_n(sel_q);
      end else if ((state_q == ST_BLANK) || (state_q == ST_DRIVE)) begin
        cnt_q <= cnt_q - 16'd1;
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.C       = sel_q[2];
  assign bus.B       = sel_q[1];
  assign bus.A       = sel_q[0];
  assign bus.G1      = dec_q.g1;
  assign bus.G2A     = dec_q.g2a;
  assign bus.G2B     = dec_q.g2b;
  assign bus.Y_N     = y_n_q;
  assign bus.BUSY    = busy_q;
  assign bus.FRAME   = frame_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: two instances (BLANK=2 and BLANK=0) share the
// same EN/MASK stream and are checked every cycle against a slot-timeline model.
module tb_decoder_scan_ctrl;
  import scan_pkg::*;

  localparam int DIV_V   = 4;
  localparam int BLANK_A = 2;
  localparam int BLANK_B = 0;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] mask = 8'h00;
  bit         chk_on = 1'b0;

  always #5 clk = ~clk;

  decoder_scan_ctrl_if if_a ();
  decoder_scan_ctrl_if if_b ();
  assign if_a.EN   = en;
  assign if_a.MASK = mask;
  assign if_b.EN   = en;
  assign if_b.MASK = mask;

  state_e st_a, st_b;

  decoder_scan_ctrl #(.DIV(DIV_V), .BLANK(BLANK_A)) dut_a (
    .CLK(clk), .CLR_N(rst_n), .bus(if_a), .dbg_state_o(st_a));
  decoder_scan_ctrl #(.DIV(DIV_V), .BLANK(BLANK_B)) dut_b (
    .CLK(clk), .CLR_N(rst_n), .bus(if_b), .dbg_state_o(st_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each active slot is a timeline of BLANK+DIV clocks; t counts from 0 at slot start.
  int m_sel[2];
  int m_t[2];
  bit m_act[2];
  bit m_frame[2];
  int blank_of[2] = '{BLANK_A, BLANK_B};

  function automatic int first_after(input logic [7:0] m, input int s);
    for (int k = 1; k <= 8; k++)
      if (m[(s + k) % 8]) return (s + k) % 8;
    return -1;
  endfunction

  task automatic model_step(input int d);
    int ns;
    m_frame[d] = 1'b0;
    if (!en) begin
      m_act[d] = 1'b0;
      m_t[d]   = 0;
    end else if (!m_act[d]) begin
      if (mask != 8'h00) begin
        m_sel[d] = first_after(mask, 7);
        m_act[d] = 1'b1;
        m_t[d]   = 0;
      end
    end else if (m_t[d] == blank_of[d] + DIV_V - 1) begin
      if (mask == 8'h00) begin
        m_act[d] = 1'b0;
        m_t[d]   = 0;
      end else begin
        ns = first_after(mask, m_sel[d]);
        m_frame[d] = (ns <= m_sel[d]);
        m_sel[d]   = ns;
        m_t[d]     = 0;
      end
    end else begin
      m_t[d]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_sel[d] = 0; m_t[d] = 0; m_act[d] = 1'b0; m_frame[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  function automatic logic [15:0] exp_vec(input int d);
    logic       drv;
    logic [2:0] s;
    logic [7:0] yn;
    drv = m_act[d] && (m_t[d] >= blank_of[d]);
    s   = 3'(m_sel[d]);
    yn  = drv ? ~(8'b1 << s) : 8'hFF;
    return {s, drv, ~drv, ~drv, yn, m_act[d], m_frame[d]};
  endfunction

  logic [15:0] act_a, act_b;
  assign act_a = {if_a.C, if_a.B, if_a.A, if_a.G1, if_a.G2A, if_a.G2B, if_a.Y_N, if_a.BUSY, if_a.FRAME};
  assign act_b = {if_b.C, if_b.B, if_b.A, if_b.G1, if_b.G2A, if_b.G2B, if_b.Y_N, if_b.BUSY, if_b.FRAME};

  function automatic logic inv_ok(input logic [7:0] yn, input logic g1, input logic g2a, input logic g2b);
    return ($countones(~yn) <= 1) && ((yn == 8'hFF) || (g1 && !g2a && !g2b));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", act_a, exp_vec(0));
      check("model_b", act_b, exp_vec(1));
      check("inv_a", 16'(inv_ok(if_a.Y_N, if_a.G1, if_a.G2A, if_a.G2B)), 16'd1);
      check("inv_b", 16'(inv_ok(if_b.Y_N, if_b.G1, if_b.G2A, if_b.G2B)), 16'd1);
      check("busy_state_a", 16'(st_a != ST_IDLE), 16'(if_a.BUSY));
      check("busy_state_b", 16'(st_b != ST_IDLE), 16'(if_b.BUSY));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_a(input string name, input bit want_eq, input logic [7:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = want_eq ? (if_a.Y_N == v) : (if_a.Y_N != v);
    end
    check(name, 16'(hit), 16'd1);
  endtask

  task automatic restart(input logic [7:0] m);
    en = 1'b0;
    @(negedge clk);
    mask = m;
    en   = 1'b1;
  endtask

  logic [7:0] start_tab[14] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                                8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFF};
  logic [7:0] skip_tab[4] = '{8'hFE, 8'hFB, 8'h7F, 8'hFE};
  logic [7:0] seen[4];
  int fa_cnt, fa_edge, fb_cnt, fb_edge, fcnt, nseen;
  logic [7:0] last_yn;
  bit done;

  initial begin
    // reset values
    rst_n = 1'b0; en = 1'b1; mask = 8'hFF;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_yn_a", 16'(if_a.Y_N), 16'h00FF);
    check("rst_dec_a", 16'({if_a.G1, if_a.G2A, if_a.G2B}), 16'b011);
    check("rst_sel_a", 16'({if_a.C, if_a.B, if_a.A}), 16'd0);
    check("rst_busy_frame_b", 16'({if_b.BUSY, if_b.FRAME}), 16'd0);

    // start-up timeline and frame period
    rst_n = 1'b1;
    fa_cnt = 0; fb_cnt = 0; fa_edge = 0; fb_edge = 0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e <= 14) check("start_yn_a", 16'(if_a.Y_N), 16'(start_tab[e-1]));
      if (e >= 3 && e <= 6) check("start_sel_a", 16'({if_a.C, if_a.B, if_a.A}), 16'd0);
      if (if_a.FRAME) begin fa_cnt++; fa_edge = e; end
      if (if_b.FRAME) begin fb_cnt++; fb_edge = e; end
    end
    check("frame_cnt_a", 16'(fa_cnt), 16'd1);
    check("frame_edge_a", 16'(fa_edge), 16'd49);
    check("frame_cnt_b", 16'(fb_cnt), 16'd1);
    check("frame_edge_b", 16'(fb_edge), 16'd33);

    // skip mask: slots 0,2,7,0
    restart(8'b1000_0101);
    nseen = 0; last_yn = 8'hFF; fcnt = 0;
    for (int i = 0; i < 200 && nseen < 4; i++) begin
      @(negedge clk);
      if (if_a.FRAME) fcnt++;
      if (if_a.Y_N != 8'hFF && if_a.Y_N != last_yn) begin
        seen[nseen] = if_a.Y_N;
        nseen++;
      end
      last_yn = if_a.Y_N;
    end
    check("skip_count", 16'(nseen), 16'd4);
    for (int i = 0; i < 4; i++) check("skip_yn", 16'(seen[i]), 16'(skip_tab[i]));
    check("skip_frames", 16'(fcnt), 16'd1);

    // single digit, BLANK=0 instance: no gap, FRAME every DIV clocks
    restart(8'h10);
    @(negedge clk);
    check("single_first_yn", 16'(if_b.Y_N), 16'h00EF);
    check("single_first_frame", 16'(if_b.FRAME), 16'd0);
    fcnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("single_yn", 16'(if_b.Y_N), 16'h00EF);
      if (if_b.FRAME) fcnt++;
    end
    check("single_frames", 16'(fcnt), 16'd3);

    // EN dropped during DRIVE of slot 3
    restart(8'hFF);
    wait_a("wait_slot3", 1'b1, 8'hF7);
    en = 1'b0;
    @(negedge clk);
    check("endrop_dec", 16'({if_a.G1, if_a.G2A, if_a.G2B}), 16'b011);
    check("endrop_yn_busy", 16'({if_a.Y_N, if_a.BUSY}), 16'h1FE);
    check("endrop_sel_hold", 16'({if_a.C, if_a.B, if_a.A}), 16'd3);

    // MASK cleared mid-DRIVE: slot completes, then IDLE without FRAME
    restart(8'hFF);
    wait_a("wait_drive0", 1'b0, 8'hFF);
    mask = 8'h00;
    fcnt = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (if_a.FRAME) fcnt++;
      if (!if_a.BUSY) done = 1'b1;
    end
    check("mask0_idle", 16'(done), 16'd1);
    check("mask0_noframe", 16'(fcnt), 16'd0);

    // async reset mid-DRIVE
    restart(8'hFF);
    wait_a("wait_drive_r", 1'b1, 8'hFD);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_yn", 16'(if_a.Y_N), 16'h00FF);
    check("arst_g1_sel", 16'({if_a.G1, if_a.C, if_a.B, if_a.A}), 16'd0);
    #1 rst_n = 1'b1;

    // random EN/MASK traffic with occasional async resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      en = ($urandom_range(0, 99) >= 3);
      if ($urandom_range(0, 99) < 4)
        mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
